dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 35 +++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the two-requester data-memory arbiter:
//   state_t   - access sequencer states
//   BE_FULL   - byte-enable pattern for a whole-word store
//   BE_NONE   - byte-enable pattern for a store that touches no lane
//   be_merge  - combine a store word into an existing word lane by lane
package dmem_arb_pkg;

  // state | meaning
  // IDLE  | no access outstanding; grants may be issued
  // RD    | memory read of latched word (load, partial or empty store)
  // WR    | memory write strobe for the latched word
  // RESP  | completion pulse to the owner
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_NONE = 4'b0000;

  // Lanes with be[i]=1 come from new_w, the rest keep old_w.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin arbiter. A grant is the acceptance itself, so the
// last-grant pointer moves whenever a grant is issued.
//   clk, rst  - clock, async active-high reset
//   i_en      - grants allowed this cycle
//   i_req     - request vector [1:0]
//   o_gnt     - one-hot (or zero) grant vector [1:0], combinational
module rr_arb2 #(
  parameter int FIRST_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Reset points at the other requester so FIRST_PRIO wins the first tie.
  localparam logic LAST_RST = (FIRST_PRIO == 0) ? 1'b1 : 1'b0;

  logic r_last;
  logic w_pick;

  assign w_pick = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign o_gnt  = (i_en && (i_req != 2'b00)) ? (w_pick ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= LAST_RST;
    end else if (o_gnt != 2'b00) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one word-wide data memory between two requesters, one access at a
// time. Loads read then respond; full stores write directly; partial stores
// read-modify-write; empty stores read and respond without writing.
//   clk, rst                 - clock, async active-high reset
//   mN_req/we/addr/wdata/be  - requester N access (held until mN_gnt)
//   mN_gnt                   - request accepted this cycle
//   mN_rvalid, mN_rdata      - completion pulse, load data
//   mem_addr/wdata/we        - memory port (word-aligned address)
//   mem_rdata                - combinational read data at mem_addr
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIRST_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_be,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_be,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            r_state;
  logic              r_owner;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_mem_we;
  logic [1:0]        r_rvalid;
  logic [31:0]       r_rdata0;
  logic [31:0]       r_rdata1;

  logic [1:0]        w_gnt;
  logic              w_en;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [3:0]        w_sel_be;

  // Grants only while idle and never during reset.
  assign w_en = (r_state == IDLE) && !rst;

  rr_arb2 #(.FIRST_PRIO(FIRST_PRIO)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_en),
    .i_req ({m1_req, m0_req}),
    .o_gnt (w_gnt)
  );

  assign w_sel_we    = w_gnt[1] ? m1_we    : m0_we;
  assign w_sel_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_gnt[1] ? m1_wdata : m0_wdata;
  assign w_sel_be    = w_gnt[1] ? m1_be    : m0_be;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= BE_NONE;
      r_wdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_rvalid    <= 2'b00;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt != 2'b00) begin
            r_owner    <= w_gnt[1];
            r_we       <= w_sel_we;
            r_be       <= w_sel_be;
            r_wdata    <= w_sel_wdata;
            r_mem_addr <= w_sel_addr & WORD_MASK;
            // A full-word store needs no old data, so it skips the read.
            if (w_sel_we && (w_sel_be == BE_FULL)) begin
              r_state     <= WR;
              r_mem_we    <= 1'b1;
              r_mem_wdata <= w_sel_wdata;
            end else begin
              r_state <= RD;
            end
          end
        end
        RD: begin
          if (r_owner) r_rdata1 <= mem_rdata;
          else         r_rdata0 <= mem_rdata;
          if (r_we && (r_be != BE_NONE)) begin
            r_state     <= WR;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= be_merge(mem_rdata, r_wdata, r_be);
          end else begin
            r_state           <= RESP;
            r_rvalid[r_owner] <= 1'b1;
          end
        end
        WR: begin
          r_mem_we          <= 1'b0;
          r_state           <= RESP;
          r_rvalid[r_owner] <= 1'b1;
        end
        RESP: begin
          r_rvalid   <= 2'b00;
          r_mem_addr <= '0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m0_gnt    = w_gnt[0];
  assign m1_gnt    = w_gnt[1];
  assign m0_rvalid = r_rvalid[0];
  assign m1_rvalid = r_rvalid[1];
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Scoreboarded bench: a monitor records every grant, computes the expected
// response from a word-array model of memory, and checks each completion.
module tb_dmem_arbiter;

  localparam int FP = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic [3:0]  m0_be = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m1_be = '0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  dmem_arbiter #(.ADDR_W(32), .FIRST_PRIO(FP)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Device memory (what the DUT really modifies) and reference model.
  logic [31:0] dev_mem [512];
  logic [31:0] ref_mem [512];
  always @(posedge clk) if (mem_we) dev_mem[mem_addr[10:2]] <= mem_wdata;
  assign mem_rdata = dev_mem[mem_addr[10:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  typedef struct {
    int          port;
    bit          we;
    logic [8:0]  widx;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] nw;
    logic [31:0] old;
    int          lat;
    int          writes;
    int          gc;
  } ent_t;

  ent_t q[$];
  int   last_g = 1 - FP;
  int   wcount = 0;

  // Monitor / scoreboard
  always @(negedge clk) begin : mon
    ent_t e;
    bit   empty0;
    int   p;
    if (!rst) begin
      empty0 = (q.size() == 0);
      chk("both_gnt", {31'd0, m0_gnt & m1_gnt}, 32'd0);
      chk("gnt_expected", {31'd0, m0_gnt | m1_gnt}, {31'd0, empty0 & (m0_req | m1_req)});
      if (empty0) begin
        chk("idle_mem_we", {31'd0, mem_we}, 32'd0);
        chk("idle_mem_addr", mem_addr, 32'd0);
      end else if (mem_we) begin
        chk("wr_addr", mem_addr, q[0].addr);
        chk("wr_data", mem_wdata, q[0].nw);
        wcount++;
      end
      if (m0_rvalid | m1_rvalid) begin
        if (empty0) chk("spurious_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("rvalid_owner", {30'd0, m1_rvalid, m0_rvalid}, (e.port == 1) ? 32'd2 : 32'd1);
          chk("latency", cyc - e.gc, e.lat);
          chk("write_count", wcount, e.writes);
          chk("resp_addr", mem_addr, e.addr);
          if (!e.we) chk("load_data", (e.port == 1) ? m1_rdata : m0_rdata, e.rdata);
        end
      end
      if (m0_gnt | m1_gnt) begin
        p = m1_gnt ? 1 : 0;
        if (m0_req && m1_req) chk("rr_alternate", p, 1 - last_g);
        else chk("single_req_wins", {31'd0, (p == 1) ? m1_req : m0_req}, 32'd1);
        last_g   = p;
        e.port   = p;
        e.we     = (p == 1) ? m1_we : m0_we;
        e.addr   = ((p == 1) ? m1_addr : m0_addr) & ~32'd3;
        e.widx   = e.addr[10:2];
        e.old    = ref_mem[e.widx];
        e.rdata  = e.old;
        e.nw     = e.old;
        e.writes = 0;
        e.lat    = 2;
        if (e.we) begin
          logic [3:0] be;
          be = (p == 1) ? m1_be : m0_be;
          e.nw = lane_merge(e.old, (p == 1) ? m1_wdata : m0_wdata, be);
          ref_mem[e.widx] = e.nw;
          e.writes = (be != 4'b0000) ? 1 : 0;
          e.lat = 1 + ((be != 4'b1111) ? 1 : 0) + e.writes;
        end
        e.gc   = cyc;
        wcount = 0;
        q.push_back(e);
      end
    end
  end

  task automatic drive(input int p, input logic rq, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (p == 0) begin m0_req = rq; m0_we = we; m0_addr = a; m0_wdata = wd; m0_be = be; end
    else        begin m1_req = rq; m1_we = we; m1_addr = a; m1_wdata = wd; m1_be = be; end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input int wd_after);
    int n;
    bit done;
    n = 0;
    done = 0;
    drive(p, 1'b1, we, a, wd, be);
    while (!done) begin
      @(negedge clk);
      if ((p == 0) ? m0_gnt : m1_gnt) done = 1;
      else if (n == wd_after) done = 1;
      else if (n > 400) begin chk("grant_timeout", n, 0); done = 1; end
      n++;
    end
    @(posedge clk);
    #1 drive(p, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(q.size() == 0 && !m0_req && !m1_req) && n < 100);
    chk("idle_timeout", {31'd0, n >= 100}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(input int p, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      int          op, gap, wda;
      logic [3:0]  be;
      logic [31:0] a;
      op  = $urandom_range(0, 3);
      a   = $urandom_range(0, 32'h7FF);
      be  = (op == 2) ? 4'hF : ($urandom_range(0, 3) == 0 ? 4'h0 : 4'($urandom));
      wda = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
      issue(p, op >= 2, a, $urandom, be, wda);
      gap = $urandom_range(0, 3);
      if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v, old_w;
    for (int i = 0; i < 512; i++) begin
      v = $urandom;
      dev_mem[i] = v;
      ref_mem[i] = v;
    end
    dev_mem[9'h040] = 32'hDEADBEEF; ref_mem[9'h040] = 32'hDEADBEEF;
    dev_mem[9'h0C0] = 32'hAABBCCDD; ref_mem[9'h0C0] = 32'hAABBCCDD;

    #3;
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_rdata0", m0_rdata, 32'd0);
    chk("rst_rdata1", m1_rdata, 32'd0);
    m0_req = 1'b1; m1_req = 1'b1;
    #1 chk("rst_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Continuous contention from reset: grants must alternate starting at FP.
    fork
      begin for (int k = 0; k < 4; k++) issue(0, 1'b0, 32'h100, 32'd0, 4'd0, -1); end
      begin for (int k = 0; k < 4; k++) issue(1, 1'b0, 32'h104 + 32'(k), 32'd0, 4'd0, -1); end
    join
    wait_idle();

    issue(0, 1'b0, 32'h100, 32'd0, 4'd0, -1);            wait_idle();
    issue(1, 1'b1, 32'h200, 32'h11223344, 4'hF, -1);     wait_idle();
    issue(1, 1'b0, 32'h200, 32'd0, 4'd0, -1);            wait_idle();
    chk("full_store_word", dev_mem[9'h080], 32'h11223344);
    issue(0, 1'b1, 32'h300, 32'h000000EE, 4'b0001, -1);  wait_idle();
    chk("partial_store_word", dev_mem[9'h0C0], 32'hAABBCCEE);
    issue(0, 1'b1, 32'h404, 32'hFFFFFFFF, 4'b0000, -1);  wait_idle();
    issue(1, 1'b0, 32'h403, 32'd0, 4'd0, -1);            wait_idle();

    // Reset while a full store sits in WR.
    old_w = dev_mem[9'h140];
    issue(1, 1'b1, 32'h500, 32'h5A5A5A5A, 4'hF, -1);
    @(negedge clk);
    chk("we_before_rst", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_rdata0", m0_rdata, 32'd0);
    chk("abort_rdata1", m1_rdata, 32'd0);
    if (q.size() > 0) ref_mem[q[0].widx] = q[0].old;
    q.delete();
    last_g = 1 - FP;
    @(posedge clk); @(posedge clk); #1;
    chk("abort_word", dev_mem[9'h140], old_w);
    rst = 1'b0;
    fork
      begin for (int k = 0; k < 2; k++) issue(0, 1'b0, 32'h500, 32'd0, 4'd0, -1); end
      begin for (int k = 0; k < 2; k++) issue(1, 1'b0, 32'h504, 32'd0, 4'd0, -1); end
    join
    wait_idle();

    fork
      rand_port(0, 120);
      rand_port(1, 120);
    join
    wait_idle();

    for (int i = 0; i < 512; i++) chk("final_mem", dev_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
